// File: rtl/tt_um_prbs_checker_shivam.sv
// Receive-side checker for the x^4+x^3+1 PRBS stream: self-seeds from the
// incoming bits, then flags and counts mismatches, resyncing after a run of misses.
module tt_um_prbs_checker_shivam #(
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(LOSS_THRESH + 1);
  localparam logic [CW-1:0]    THRESH_M1 = CW'(LOSS_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {SEED, LOCKED} state_t;

  state_t           r_state,     w_state;
  logic [3:0]       r_h,         w_h;
  logic [2:0]       r_seed_cnt,  w_seed_cnt;
  logic [CW-1:0]    r_consec,    w_consec;
  logic [CNT_W-1:0] r_err_cnt,   w_err_cnt;
  logic             r_err_pulse, w_err_pulse;
  logic             r_lock_lost, w_lock_lost;

  logic       w_v, w_d, w_clr, w_p;
  logic [3:0] w_h_rx, w_h_fly;

  assign w_v     = ena & ui_in[1];
  assign w_d     = ui_in[0];
  assign w_clr   = ui_in[2];
  assign w_p     = r_h[3] ^ r_h[2];
  assign w_h_rx  = {r_h[2:0], w_d};
  // Flywheel: on a miss the predicted bit is kept so one flipped bit cannot misalign h.
  assign w_h_fly = {r_h[2:0], w_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SEED;
      r_h         <= '0;
      r_seed_cnt  <= '0;
      r_consec    <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_h         <= w_h;
      r_seed_cnt  <= w_seed_cnt;
      r_consec    <= w_consec;
      r_err_cnt   <= w_err_cnt;
      r_err_pulse <= w_err_pulse;
      r_lock_lost <= w_lock_lost;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_h         = r_h;
    w_seed_cnt  = r_seed_cnt;
    w_consec    = r_consec;
    w_err_cnt   = r_err_cnt;
    w_err_pulse = 1'b0;
    w_lock_lost = r_lock_lost;
    if (w_v) begin
      unique case (r_state)
        SEED: begin
          w_h = w_h_rx;
          if (r_seed_cnt != 3'd4) w_seed_cnt = r_seed_cnt + 3'd1;
          // All-zero is the LFSR lock-up state, so keep seeding until a 1 arrives.
          if ((r_seed_cnt >= 3'd3) && (w_h_rx != 4'h0)) w_state = LOCKED;
        end
        LOCKED: begin
          if (w_d == w_p) begin
            w_h      = w_h_rx;
            w_consec = '0;
          end else begin
            w_h         = w_h_fly;
            w_err_pulse = 1'b1;
            if (r_err_cnt != CNT_MAX) w_err_cnt = r_err_cnt + 1'b1;
            if (r_consec == THRESH_M1) begin
              w_state     = SEED;
              w_seed_cnt  = '0;
              w_consec    = '0;
              w_lock_lost = 1'b1;
            end else begin
              w_consec = r_consec + 1'b1;
            end
          end
        end
        default: w_state = SEED;
      endcase
    end
    if (w_clr) begin
      w_err_cnt   = '0;
      w_lock_lost = 1'b0;
    end
  end

  assign uo_out  = 8'(r_err_cnt);
  assign uio_out = {4'h0, (r_state == SEED), r_lock_lost, r_err_pulse, (r_state == LOCKED)};
  assign uio_oe  = 8'h0F;

  logic w_unused;
  assign w_unused = &{1'b0, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_prbs_checker_shivam.sv
// Directed bench for the PRBS checker: a bit-level reference model checks every
// cycle, two instances cover the default loss threshold and a 255 threshold.
module tb_tt_um_prbs_checker_shivam;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_a, uio_a, oe_a;
  logic [7:0] uo_b, uio_b, oe_b;

  int n_chk  = 0;
  int n_fail = 0;
  int g      = 0;
  logic [14:0] pat = 15'b100011110101100;  // generator bits from seed 0001, bit k at [k]

  tt_um_prbs_checker_shivam dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_a),
    .uio_in(uio_in), .uio_out(uio_a), .uio_oe(oe_a));

  tt_um_prbs_checker_shivam #(.LOSS_THRESH(255), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_b),
    .uio_in(uio_in), .uio_out(uio_b), .uio_oe(oe_b));

  always #5 clk = ~clk;

  typedef struct {
    bit         locked;
    logic [3:0] h;
    int         seen;
    int         miss;
    int         cnt;
    bit         pulse;
    bit         lost;
  } model_t;

  model_t m[2];

  function automatic model_t mreset();
    model_t r;
    r.locked = 0; r.h = 4'h0; r.seen = 0; r.miss = 0; r.cnt = 0; r.pulse = 0; r.lost = 0;
    return r;
  endfunction

  function automatic model_t mstep(model_t cur, bit v, bit d, bit clr, int th);
    model_t n = cur;
    bit p;
    n.pulse = 0;
    if (v) begin
      if (!cur.locked) begin
        n.h    = {cur.h[2:0], d};
        n.seen = cur.seen + 1;
        if (n.seen >= 4 && n.h != 4'h0) n.locked = 1;
      end else begin
        p = cur.h[3] ^ cur.h[2];
        if (d == p) begin
          n.h    = {cur.h[2:0], d};
          n.miss = 0;
        end else begin
          n.pulse = 1;
          n.cnt   = (cur.cnt < 255) ? cur.cnt + 1 : 255;
          n.miss  = cur.miss + 1;
          n.h     = {cur.h[2:0], p};
          if (n.miss >= th) begin
            n.locked = 0; n.seen = 0; n.miss = 0; n.lost = 1;
          end
        end
      end
    end
    if (clr) begin
      n.cnt  = 0;
      n.lost = 0;
    end
    return n;
  endfunction

  function automatic logic [23:0] mexp(model_t x);
    return {8'(x.cnt), 4'h0, ~x.locked, x.lost, x.pulse, x.locked, 8'h0F};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], ena & ui_in[1], ui_in[0], ui_in[2], 3);
      m[1] <= mstep(m[1], ena & ui_in[1], ui_in[0], ui_in[2], 255);
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_a", {uo_a, uio_a, oe_a}, mexp(m[0]));
    chk("model_b", {uo_b, uio_b, oe_b}, mexp(m[1]));
  end

  task automatic step(input bit d, input bit v, input bit clr, input bit en);
    ena   = en;
    ui_in = {5'b0, clr, v, d};
    @(negedge clk);
  endtask

  task automatic good();
    step(pat[g % 15], 1, 0, 1);
    g++;
  endtask

  task automatic bad(input bit clr);
    step(~pat[g % 15], 1, clr, 1);
    g++;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_uo", {16'h0, uo_a}, 24'h00);
    chk("rst_uio", {16'h0, uio_a}, 24'h08);
    chk("rst_oe", {16'h0, oe_a}, 24'h0F);
    rst_n = 1'b1;
    repeat (10) step(1, 0, 0, 1);
    chk("idle_uio", {16'h0, uio_a}, 24'h08);

    // lock on generator stream
    repeat (3) good();
    chk("seed3_uio", {16'h0, uio_a}, 24'h08);
    good();
    chk("lock4_uio", {16'h0, uio_a}, 24'h01);
    for (int i = 0; i < 60; ) begin
      case ($urandom_range(0, 3))
        0: step($urandom_range(0, 1), 0, 0, 1);
        1: step($urandom_range(0, 1), 1, 0, 0);
        default: begin good(); i++; end
      endcase
    end
    chk("clean_uo", {16'h0, uo_a}, 24'h00);

    // single error
    bad(0);
    chk("err1_uo", {16'h0, uo_a}, 24'h01);
    chk("err1_uio", {16'h0, uio_a}, 24'h03);
    good();
    chk("err1_after", {16'h0, uio_a}, 24'h01);
    repeat (20) good();
    step(0, 0, 1, 1);
    chk("clr_uo", {16'h0, uo_a}, 24'h00);

    // loss of lock after three misses, then relock
    repeat (3) bad(0);
    chk("loss_uo", {16'h0, uo_a}, 24'h03);
    chk("loss_uio", {16'h0, uio_a}, 24'h0E);
    repeat (3) good();
    chk("reseed_uio", {16'h0, uio_a}, 24'h0C);
    good();
    chk("relock_uio", {16'h0, uio_a}, 24'h05);
    step(0, 0, 1, 1);
    chk("clr2_uo", {16'h0, uo_a}, 24'h00);
    chk("clr2_uio", {16'h0, uio_a}, 24'h01);

    // async reset mid-LOCKED, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_uio", {16'h0, uio_a}, 24'h08);
    chk("arst_uo", {16'h0, uo_b}, 24'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // zero stream never locks; lock once the first 1 enters h
    repeat (20) step(0, 1, 0, 1);
    chk("zero_uio", {16'h0, uio_a}, 24'h08);
    g = 14;
    good();
    chk("zero_lock", {16'h0, uio_a}, 24'h01);
    repeat (30) good();

    // clear collides with a miss
    bad(1);
    chk("coll_uo", {16'h0, uo_a}, 24'h00);
    chk("coll_uio", {16'h0, uio_a}, 24'h03);
    good();

    // saturation
    repeat (300) begin bad(0); good(); end
    chk("sat_uo_b", {16'h0, uo_b}, 24'hFF);
    chk("sat_uo_a", {16'h0, uo_a}, 24'hFF);
    bad(0);
    chk("sat_hold", {16'h0, uo_b}, 24'hFF);
    chk("sat_pulse", {16'h0, uio_b}, 24'h03);
    good();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
